// File: rtl/mem_arb_pkg.sv
// Shared definitions for the system RAM arbiter: state encoding and the
// owner-index width helper used by the top level and the winner picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    CPU_RUN = 2'd0,
    DRAIN   = 2'd1,
    GRANT   = 2'd2
  } arbState_t;

  // Owner index width; a single client still needs one bit to index with.
  function automatic int ownerWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_picker.sv
// Winner select for the RAM arbiter. Default build is fixed priority with
// index 0 highest. Defining MEM_ARB_ROUND_ROBIN_EN switches to a rotating
// search that starts one past the last owner.
module arb_picker
  import mem_arb_pkg::*;
#(
  parameter int N_CLIENTS = 2,
  parameter int OW        = ownerWidth(N_CLIENTS)
) (
  input  logic [N_CLIENTS-1:0] i_req,
  input  logic [OW-1:0]        i_lastOwner,
  output logic [OW-1:0]        o_winner,
  output logic                 o_anyReq
);

  assign o_anyReq = |i_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [OW-1:0] w_idx;
  logic          w_found;

  // Search upward from lastOwner+1 with wrap-around; the first hit wins.
  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      w_idx = OW'((int'(i_lastOwner) + 1 + k) % N_CLIENTS);
      if (!w_found && i_req[w_idx]) begin
        o_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end
`else
  logic w_unusedLastOwner;
  assign w_unusedLastOwner = ^i_lastOwner;

  // Scan from the top down so the lowest asserted index is the last to land.
  always_comb begin
    o_winner = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (i_req[i]) o_winner = OW'(i);
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shared system RAM arbiter between the 6502 CPU and N_CLIENTS block clients.
// The CPU is only stalled at SYNC (opcode fetch); clients own the RAM through
// a req/grant handshake. Optional macro MEM_ARB_ROUND_ROBIN_EN selects
// round-robin client arbitration instead of fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int N_CLIENTS  = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [DATA_WIDTH-1:0]            cpu_wdata,
  input  logic                             cpu_we,
  input  logic                             cpu_sync,
  output logic                             cpu_ready,
  output logic [DATA_WIDTH-1:0]            cpu_rdata,
  input  logic [N_CLIENTS-1:0]             cli_req,
  output logic [N_CLIENTS-1:0]             cli_grant,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]  cli_addr,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0]  cli_wdata,
  input  logic [N_CLIENTS-1:0]             cli_we,
  output logic [DATA_WIDTH-1:0]            cli_rdata,
  output logic [N_CLIENTS-1:0]             cli_rvalid,
  output logic [ADDR_WIDTH-1:0]            ram_raddr,
  output logic [ADDR_WIDTH-1:0]            ram_waddr,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  output logic                             ram_we,
  input  logic [DATA_WIDTH-1:0]            ram_rdata
);

  localparam int OW = ownerWidth(N_CLIENTS);

  arbState_t             r_state;
  arbState_t             w_stateNext;
  logic [OW-1:0]         r_owner;
  logic [OW-1:0]         w_ownerNext;
  logic                  r_fresh;
  logic [N_CLIENTS-1:0]  r_rvalid;
  logic [N_CLIENTS-1:0]  w_rvalidNext;
  logic [OW-1:0]         w_lastOwner;
  logic [OW-1:0]         w_winner;
  logic                  w_anyReq;
  logic                  w_ready;
  logic [N_CLIENTS-1:0]  w_grant;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_we;

  arb_picker #(
    .N_CLIENTS (N_CLIENTS),
    .OW        (OW)
  ) u_picker (
    .i_req       (cli_req),
    .i_lastOwner (w_lastOwner),
    .o_winner    (w_winner),
    .o_anyReq    (w_anyReq)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [OW-1:0] r_lastOwner;

  // Remember who owned the RAM last so the search rotates; the reset value
  // makes client 0 the first winner.
  always_ff @(posedge clk) begin
    if (reset) r_lastOwner <= OW'(N_CLIENTS - 1);
    else if (w_stateNext == GRANT) r_lastOwner <= w_ownerNext;
  end

  assign w_lastOwner = r_lastOwner;
`else
  assign w_lastOwner = OW'(N_CLIENTS - 1);
`endif

  // State, owner and read-valid pipeline; r_fresh marks the first cycle out
  // of reset, when the CPU has not started and a client may take over at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= CPU_RUN;
      r_owner  <= '0;
      r_fresh  <= 1'b1;
      r_rvalid <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_owner  <= w_ownerNext;
      r_fresh  <= 1'b0;
      r_rvalid <= w_rvalidNext;
    end
  end

  // Next-state logic and the RAM mux; reads by the owner are tagged for
  // rvalid only while it still holds its request, so nothing trails a drop.
  always_comb begin
    w_stateNext  = r_state;
    w_ownerNext  = r_owner;
    w_rvalidNext = '0;
    w_ready      = 1'b1;
    w_grant      = '0;
    w_addr       = cpu_addr;
    w_wdata      = cpu_wdata;
    w_we         = cpu_we;
    case (r_state)
      CPU_RUN, DRAIN: begin
        if (r_fresh && w_anyReq) w_ready = 1'b0;
        if (w_anyReq) begin
          if (cpu_sync || r_fresh) begin
            w_stateNext = GRANT;
            w_ownerNext = w_winner;
          end else begin
            w_stateNext = DRAIN;
          end
        end else begin
          w_stateNext = CPU_RUN;
        end
      end
      GRANT: begin
        w_ready          = 1'b0;
        w_grant[r_owner] = 1'b1;
        w_addr           = cli_addr[int'(r_owner) * ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata          = cli_wdata[int'(r_owner) * DATA_WIDTH +: DATA_WIDTH];
        w_we             = cli_we[r_owner];
        if (cli_req[r_owner]) begin
          w_rvalidNext[r_owner] = ~cli_we[r_owner];
        end else if (w_anyReq) begin
          w_ownerNext = w_winner;
        end else begin
          w_stateNext = CPU_RUN;
        end
      end
      default: begin
        w_stateNext = CPU_RUN;
      end
    endcase
  end

  // While reset is high every control and RAM output is held at zero.
  assign cpu_ready  = w_ready & ~reset;
  assign cli_grant  = reset ? '0 : w_grant;
  assign cli_rvalid = reset ? '0 : r_rvalid;
  assign ram_raddr  = reset ? '0 : w_addr;
  assign ram_waddr  = reset ? '0 : w_addr;
  assign ram_wdata  = reset ? '0 : w_wdata;
  assign ram_we     = w_we & ~reset;
  assign cpu_rdata  = ram_rdata;
  assign cli_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural 1-cycle registered
// RAM. Inputs change on the falling edge and outputs are sampled 1 time unit
// later. Build with +define+MEM_ARB_ROUND_ROBIN_EN to check rotation.
module tb_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int NC = 2;

  logic             clk;
  logic             reset;
  logic [AW-1:0]    cpu_addr;
  logic [DW-1:0]    cpu_wdata;
  logic             cpu_we;
  logic             cpu_sync;
  logic             cpu_ready;
  logic [DW-1:0]    cpu_rdata;
  logic [NC-1:0]    cli_req;
  logic [NC-1:0]    cli_grant;
  logic [NC*AW-1:0] cli_addr;
  logic [NC*DW-1:0] cli_wdata;
  logic [NC-1:0]    cli_we;
  logic [DW-1:0]    cli_rdata;
  logic [NC-1:0]    cli_rvalid;
  logic [AW-1:0]    ram_raddr;
  logic [AW-1:0]    ram_waddr;
  logic [DW-1:0]    ram_wdata;
  logic             ram_we;
  logic [DW-1:0]    ram_rdata;

  logic             tbLoadEn;
  logic [AW-1:0]    tbLoadAddr;
  logic [DW-1:0]    tbLoadData;
  logic [DW-1:0]    mem [0:2047];

  int checks;
  int failures;

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .N_CLIENTS  (NC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_sync   (cpu_sync),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cli_req    (cli_req),
    .cli_grant  (cli_grant),
    .cli_addr   (cli_addr),
    .cli_wdata  (cli_wdata),
    .cli_we     (cli_we),
    .cli_rdata  (cli_rdata),
    .cli_rvalid (cli_rvalid),
    .ram_raddr  (ram_raddr),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
  );

  // 100 MHz-style free-running clock for simulation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with a bench-side preload port and registered read.
  always @(posedge clk) begin
    if (tbLoadEn) mem[tbLoadAddr] <= tbLoadData;
    else if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus();
    reset     = 1'b1;
    cpu_addr  = 11'h123;
    cpu_wdata = 8'h00;
    cpu_we    = 1'b1;
    cpu_sync  = 1'b0;
    cli_req   = '0;
    cli_addr  = '0;
    cli_wdata = '0;
    cli_we    = '0;
    tbLoadEn  = 1'b0;
    tbLoadAddr = '0;
    tbLoadData = '0;
  endtask

  task automatic preloadRam();
    logic [AW-1:0] addrs [6];
    logic [DW-1:0] datas [6];
    addrs = '{11'h200, 11'h201, 11'h202, 11'h203, 11'h010, 11'h011};
    datas = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h00, 8'h33};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tbLoadEn   = 1'b1;
      tbLoadAddr = addrs[i];
      tbLoadData = datas[i];
    end
    @(negedge clk);
    tbLoadEn = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (cpu_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready: got %b want 0", cpu_ready); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_we: got %b want 0", ram_we); end
    checks++; if (cli_grant !== 2'b00) begin failures++; $display("[TB] FAIL rst_grant: got %b want 00", cli_grant); end
    checks++; if (ram_raddr !== 11'h000) begin failures++; $display("[TB] FAIL rst_raddr: got %h want 000", ram_raddr); end
    @(negedge clk);
    reset  = 1'b0;
    cpu_we = 1'b0;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_rst_ready: got %b want 1", cpu_ready); end
    checks++; if (ram_raddr !== 11'h123) begin failures++; $display("[TB] FAIL post_rst_raddr: got %h want 123", ram_raddr); end
    checks++; if (cli_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL post_rst_rvalid: got %b want 00", cli_rvalid); end
    @(negedge clk);
  endtask

  task automatic test_reset_req();
    @(negedge clk);
    reset   = 1'b1;
    cli_req = 2'b01;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (cpu_ready !== 1'b0) begin failures++; $display("[TB] FAIL fresh_ready: got %b want 0", cpu_ready); end
    checks++; if (cli_grant !== 2'b00) begin failures++; $display("[TB] FAIL fresh_grant0: got %b want 00", cli_grant); end
    @(negedge clk);
    #1;
    checks++; if (cli_grant !== 2'b01) begin failures++; $display("[TB] FAIL fresh_grant1: got %b want 01", cli_grant); end
    checks++; if (cpu_ready !== 1'b0) begin failures++; $display("[TB] FAIL fresh_ready1: got %b want 0", cpu_ready); end
    @(negedge clk);
    cli_req = 2'b00;
    #1;
    checks++; if (cli_grant !== 2'b01) begin failures++; $display("[TB] FAIL fresh_hold: got %b want 01", cli_grant); end
    @(negedge clk);
    #1;
    checks++; if (cli_grant !== 2'b00) begin failures++; $display("[TB] FAIL fresh_drop: got %b want 00", cli_grant); end
    checks++; if (cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL fresh_back: got %b want 1", cpu_ready); end
  endtask

  task automatic test_drain();
    @(negedge clk);
    cli_req  = 2'b10;
    cpu_sync = 1'b0;
    cpu_addr = 11'h055;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL drain_ready0: got %b want 1", cpu_ready); end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      #1;
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL drain_ready%0d: got %b want 1", i, cpu_ready); end
    end
    @(negedge clk);
    cpu_sync = 1'b1;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL drain_sync_ready: got %b want 1", cpu_ready); end
    checks++; if (cli_grant !== 2'b00) begin failures++; $display("[TB] FAIL drain_sync_grant: got %b want 00", cli_grant); end
    @(negedge clk);
    cpu_sync = 1'b0;
    cli_addr = {11'h201, 11'h000};
    cli_we   = 2'b00;
    #1;
    checks++; if (cpu_ready !== 1'b0) begin failures++; $display("[TB] FAIL drain_stall: got %b want 0", cpu_ready); end
    checks++; if (cli_grant !== 2'b10) begin failures++; $display("[TB] FAIL drain_grant: got %b want 10", cli_grant); end
    checks++; if (ram_raddr !== 11'h201) begin failures++; $display("[TB] FAIL drain_raddr: got %h want 201", ram_raddr); end
    @(negedge clk);
    cli_req = 2'b00;
    #1;
    checks++; if (cli_grant !== 2'b10) begin failures++; $display("[TB] FAIL drain_hold: got %b want 10", cli_grant); end
    checks++; if (cli_rvalid !== 2'b10) begin failures++; $display("[TB] FAIL drain_rvalid: got %b want 10", cli_rvalid); end
    checks++; if (cli_rdata !== 8'h6B) begin failures++; $display("[TB] FAIL drain_rdata: got %h want 6b", cli_rdata); end
    @(negedge clk);
    #1;
    checks++; if (cli_grant !== 2'b00) begin failures++; $display("[TB] FAIL drain_release: got %b want 00", cli_grant); end
    checks++; if (cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL drain_resume: got %b want 1", cpu_ready); end
    checks++; if (cli_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL drain_no_rvalid: got %b want 00", cli_rvalid); end
    checks++; if (ram_raddr !== 11'h055) begin failures++; $display("[TB] FAIL drain_cpu_addr: got %h want 055", ram_raddr); end
  endtask

  task automatic test_drain_abort();
    @(negedge clk);
    cli_req  = 2'b01;
    cpu_sync = 1'b0;
    @(negedge clk);
    cli_req  = 2'b00;
    cpu_sync = 1'b1;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL abort_ready: got %b want 1", cpu_ready); end
    @(negedge clk);
    cpu_sync = 1'b0;
    #1;
    checks++; if (cli_grant !== 2'b00) begin failures++; $display("[TB] FAIL abort_grant: got %b want 00", cli_grant); end
    checks++; if (cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL abort_run: got %b want 1", cpu_ready); end
  endtask

  task automatic test_client_read();
    logic [DW-1:0] expRd [4];
    expRd = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    @(negedge clk);
    cli_req  = 2'b01;
    cpu_sync = 1'b1;
    @(negedge clk);
    cpu_sync = 1'b0;
    cli_addr = {11'h000, 11'h200};
    cli_we   = 2'b00;
    #1;
    checks++; if (cli_grant !== 2'b01) begin failures++; $display("[TB] FAIL rd_grant: got %b want 01", cli_grant); end
    checks++; if (cli_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL rd_rvalid_first: got %b want 00", cli_rvalid); end
    checks++; if (ram_raddr !== 11'h200) begin failures++; $display("[TB] FAIL rd_raddr0: got %h want 200", ram_raddr); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      cli_addr[AW-1:0] = AW'(11'h200 + k);
      #1;
      checks++; if (cli_rvalid !== 2'b01) begin failures++; $display("[TB] FAIL rd_rvalid%0d: got %b want 01", k, cli_rvalid); end
      checks++; if (cli_rdata !== expRd[k-1]) begin failures++; $display("[TB] FAIL rd_data%0d: got %h want %h", k, cli_rdata, expRd[k-1]); end
    end
    @(negedge clk);
    cli_req = 2'b00;
    #1;
    checks++; if (cli_rvalid !== 2'b01) begin failures++; $display("[TB] FAIL rd_rvalid4: got %b want 01", cli_rvalid); end
    checks++; if (cli_rdata !== expRd[3]) begin failures++; $display("[TB] FAIL rd_data4: got %h want %h", cli_rdata, expRd[3]); end
    @(negedge clk);
    #1;
    checks++; if (cli_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL rd_after_drop: got %b want 00", cli_rvalid); end
    checks++; if (cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL rd_resume: got %b want 1", cpu_ready); end
  endtask

  task automatic test_client_write();
    @(negedge clk);
    cli_req  = 2'b10;
    cpu_sync = 1'b1;
    @(negedge clk);
    cpu_sync  = 1'b0;
    cli_addr  = {11'h010, 11'h011};
    cli_wdata = {8'hAA, 8'h55};
    cli_we    = 2'b11;
    #1;
    checks++; if (cli_grant !== 2'b10) begin failures++; $display("[TB] FAIL wr_grant: got %b want 10", cli_grant); end
    checks++; if (ram_we !== 1'b1) begin failures++; $display("[TB] FAIL wr_we: got %b want 1", ram_we); end
    checks++; if (ram_waddr !== 11'h010) begin failures++; $display("[TB] FAIL wr_waddr: got %h want 010", ram_waddr); end
    checks++; if (ram_wdata !== 8'hAA) begin failures++; $display("[TB] FAIL wr_wdata: got %h want aa", ram_wdata); end
    @(negedge clk);
    cli_we = 2'b00;
    #1;
    checks++; if (cli_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL wr_no_rvalid: got %b want 00", cli_rvalid); end
    @(negedge clk);
    cli_req = 2'b00;
    cli_we  = 2'b01;
    #1;
    checks++; if (cli_rvalid !== 2'b10) begin failures++; $display("[TB] FAIL wr_readback_valid: got %b want 10", cli_rvalid); end
    checks++; if (cli_rdata !== 8'hAA) begin failures++; $display("[TB] FAIL wr_readback: got %h want aa", cli_rdata); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("[TB] FAIL wr_nonowner_we: got %b want 0", ram_we); end
    @(negedge clk);
    cli_we = 2'b00;
    #1;
    checks++; if (mem[11'h010] !== 8'hAA) begin failures++; $display("[TB] FAIL wr_mem010: got %h want aa", mem[11'h010]); end
    checks++; if (mem[11'h011] !== 8'h33) begin failures++; $display("[TB] FAIL wr_mem011: got %h want 33", mem[11'h011]); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cli_req  = 2'b11;
    cpu_sync = 1'b1;
    cli_addr = {11'h203, 11'h200};
    cli_we   = 2'b00;
    @(negedge clk);
    cpu_sync = 1'b0;
    #1;
    checks++; if (cli_grant !== 2'b01) begin failures++; $display("[TB] FAIL b2b_first: got %b want 01", cli_grant); end
    checks++; if (cpu_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready1: got %b want 0", cpu_ready); end
    @(negedge clk);
    cli_req = 2'b10;
    #1;
    checks++; if (cli_grant !== 2'b01) begin failures++; $display("[TB] FAIL b2b_hold: got %b want 01", cli_grant); end
    checks++; if (cli_rvalid !== 2'b01) begin failures++; $display("[TB] FAIL b2b_rvalid0: got %b want 01", cli_rvalid); end
    @(negedge clk);
    #1;
    checks++; if (cli_grant !== 2'b10) begin failures++; $display("[TB] FAIL b2b_handoff: got %b want 10", cli_grant); end
    checks++; if (cpu_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready2: got %b want 0", cpu_ready); end
    checks++; if (cli_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL b2b_gap: got %b want 00", cli_rvalid); end
    checks++; if (ram_raddr !== 11'h203) begin failures++; $display("[TB] FAIL b2b_raddr: got %h want 203", ram_raddr); end
    @(negedge clk);
    cli_req = 2'b00;
    #1;
    checks++; if (cli_rvalid !== 2'b10) begin failures++; $display("[TB] FAIL b2b_rvalid1: got %b want 10", cli_rvalid); end
    checks++; if (cli_rdata !== 8'h8D) begin failures++; $display("[TB] FAIL b2b_rdata: got %h want 8d", cli_rdata); end
    @(negedge clk);
    #1;
    checks++; if (cli_grant !== 2'b00) begin failures++; $display("[TB] FAIL b2b_release: got %b want 00", cli_grant); end
    checks++; if (cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_resume: got %b want 1", cpu_ready); end
  endtask

  task automatic test_priority_repeat();
    logic [NC-1:0] expGrant [2];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    expGrant = '{2'b01, 2'b10};
`else
    expGrant = '{2'b01, 2'b01};
`endif
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      cli_req  = 2'b11;
      cpu_sync = 1'b1;
      @(negedge clk);
      cpu_sync = 1'b0;
      cli_req  = 2'b00;
      #1;
      checks++; if (cli_grant !== expGrant[r]) begin failures++; $display("[TB] FAIL prio_round%0d: got %b want %b", r, cli_grant, expGrant[r]); end
      @(negedge clk);
      #1;
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL prio_resume%0d: got %b want 1", r, cpu_ready); end
    end
  endtask

  task automatic test_reset_mid_grant();
    @(negedge clk);
    cli_req  = 2'b01;
    cpu_sync = 1'b1;
    @(negedge clk);
    cpu_sync = 1'b0;
    cli_addr = {11'h000, 11'h200};
    cli_we   = 2'b00;
    #1;
    checks++; if (cli_grant !== 2'b01) begin failures++; $display("[TB] FAIL mid_grant: got %b want 01", cli_grant); end
    @(negedge clk);
    reset  = 1'b1;
    cli_we = 2'b01;
    #1;
    checks++; if (cli_grant !== 2'b00) begin failures++; $display("[TB] FAIL mid_rst_grant: got %b want 00", cli_grant); end
    checks++; if (cli_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL mid_rst_rvalid: got %b want 00", cli_rvalid); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_we: got %b want 0", ram_we); end
    checks++; if (cpu_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ready: got %b want 0", cpu_ready); end
    @(negedge clk);
    #1;
    checks++; if (cli_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL mid_rst_rvalid2: got %b want 00", cli_rvalid); end
    checks++; if (cpu_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ready2: got %b want 0", cpu_ready); end
    @(negedge clk);
    reset   = 1'b0;
    cli_req = 2'b00;
    cli_we  = 2'b00;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_release: got %b want 1", cpu_ready); end
    checks++; if (cli_grant !== 2'b00) begin failures++; $display("[TB] FAIL mid_rst_nogrant: got %b want 00", cli_grant); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    applyStimulus();
    preloadRam();
    test_reset();
    test_reset_req();
    test_drain();
    test_drain_abort();
    test_client_read();
    test_client_write();
    test_back_to_back();
    test_priority_repeat();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
